tick_period_meter: RTL
======================

# tick_period_meter

Measures the interval, in `clk` cycles, between successive single-cycle ticks on a strobe input, such as the laser trigger tick train produced by the team's clock decimator. Each measured period is delivered on a valid/ready output. The block reports lock when consecutive periods agree, and it flags loss of the tick train by timeout. It sits at the receive end of a tick link and recovers the decimation factor N in use at the far end.

## Interface
- `WIDTH`, default 32: width of the period counter and of `period_o`.
- `TIMEOUT`, default 2^20: largest accepted period in cycles; must be at least 1 and at most 2^WIDTH-1.
- `TOL`, default 1: jitter tolerance in cycles; used only when `TICK_PERIOD_METER_JITTER_EN` is defined.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `x`, input, 1: tick strobe; every cycle with `x==1` counts as one tick.
- `period_o`, output, WIDTH: last accepted period in cycles.
- `valid_o`, output, 1: `period_o` holds an untransferred sample.
- `ready_i`, input, 1: the consumer accepts `period_o` when `valid_o` and `ready_i` are both high.
- `locked_o`, output, 1: the tick train is stable.
- `timeout_o`, output, 1: one-cycle pulse on loss of the tick train.
- `overrun_o`, output, 1: one-cycle pulse when a sample is dropped.

## Operation
- Reset values: `period_o=0`, `valid_o=0`, `locked_o=0`, `timeout_o=0`, `overrun_o=0`, state IDLE, internal counter `cnt=0`, previous period `prev=0`.
- Counter behaviour:
  - On a tick cycle, `cnt<=1`.
  - On any other cycle, `cnt<=cnt+1`, saturating at 2^WIDTH-1.
  - On a tick cycle, the measured period is `cnt`. A decimator running with factor N therefore measures N; a constant-high `x` measures 1.
- State machine:
  - IDLE: `cnt` and period checks are ignored. A tick moves to ARMED; no sample is emitted.
  - ARMED: a tick emits a sample, stores it in `prev`, and moves to TRACK.
  - TRACK: a tick emits a sample. If the sample equals `prev`, go to LOCKED; otherwise stay in TRACK. `prev` is always updated.
  - LOCKED: a tick emits a sample. If the sample differs from `prev`, go to TRACK. `prev` is always updated.
  - ARMED, TRACK or LOCKED: a cycle with `x==0` and `cnt==TIMEOUT` moves to IDLE, pulses `timeout_o`, and clears `prev`.
- `locked_o` is high exactly while the state is LOCKED.
- Emitting a sample:
  - If `valid_o==0`, or `valid_o&&ready_i` in the same cycle, load `period_o` and set `valid_o=1`.
  - Otherwise keep `period_o` unchanged, drop the new sample, and pulse `overrun_o`. State and lock tracking still use the dropped sample.
- `valid_o` clears after a transfer when no new sample loads in that same cycle.
- `period_o` is stable while `valid_o` is high and `ready_i` is low.
- Emitted periods always lie in the range 1..TIMEOUT.
- Reset asserted mid-operation forces all reset values immediately; any pending sample is lost.

## Timing
- A tick at cycle t updates `period_o`, `valid_o`, `locked_o` and `overrun_o` on the edge ending cycle t, so they are visible in cycle t+1. Latency is 1 cycle.
- A timeout at cycle t raises `timeout_o` and drops `locked_o` in cycle t+1. `timeout_o` lasts one cycle.
- A tick and a transfer in the same cycle are legal and produce no overrun.
- `ready_i` is not required to wait for `valid_o`.
- There is no combinational path from any input to any output.

## Configuration
- `TICK_PERIOD_METER_JITTER_EN` defined: samples within ±`TOL` of `prev` count as equal for the TRACK→LOCKED and LOCKED→TRACK decisions. Emitted values are unchanged.
- `TICK_PERIOD_METER_JITTER_EN` undefined: equality is exact, and `TOL` is ignored.

## Structure
- Package `tick_period_meter_pkg`:
  - state enum `tpm_state_t` with IDLE, ARMED, TRACK, LOCKED;
  - default constants for `WIDTH`, `TIMEOUT` and `TOL`.
- One sub-module, `tick_interval_counter`: the saturating `cnt` register, the tick-load logic, and the `cnt==TIMEOUT` compare.
- The top level holds the state machine, the `prev` register, the output register and the handshake logic.

## Test plan
- Ticks every 4 cycles, `ready_i=1` → first sample 4 emitted after the second tick; `locked_o=1` one cycle after the third tick; steady samples of 4.
- `x` held high, `ready_i=1` → samples of 1 every cycle; lock after the third cycle.
- `ready_i=0` with ticks every 3 cycles → `period_o=3` held and `valid_o=1`; `overrun_o` pulses on each later tick; raising `ready_i` completes one transfer.
- `TIMEOUT=10`, one tick then silence → `timeout_o` pulses 11 cycles after the tick (cnt counts 1..10 before the timeout check) and the state returns to IDLE; a gap of exactly 10 is accepted as period 10.
- Locked at period 8, then gaps of 9, 8 → LOCKED→TRACK on the 9, TRACK→LOCKED on the following 8 only when the two samples match. With the macro defined and `TOL=1`, lock holds throughout.
- `rst_n` pulsed low while LOCKED with `valid_o=1` → all outputs 0 immediately; the next sample appears only after two new ticks.

Source files
------------

// File: rtl/tick_period_meter_pkg.sv
// Shared types and default parameters for the tick period meter.
package tick_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } tpm_state_t;

    localparam int          TPM_WIDTH   = 32;
    localparam int unsigned TPM_TIMEOUT = 32'd1 << 20;
    localparam int unsigned TPM_TOL     = 1;

endpackage

// File: rtl/tick_period_meter_if.sv
// Tick input plus period/status output bundle of the tick period meter.
interface tick_period_meter_if
    import tick_period_meter_pkg::*;
#(
    parameter int WIDTH = TPM_WIDTH
);
    logic             x;
    logic [WIDTH-1:0] period_o;
    logic             valid_o;
    logic             ready_i;
    logic             locked_o;
    logic             timeout_o;
    logic             overrun_o;

    modport master (
        input  x, ready_i,
        output period_o, valid_o, locked_o, timeout_o, overrun_o
    );

    modport slave (
        output x, ready_i,
        input  period_o, valid_o, locked_o, timeout_o, overrun_o
    );
endinterface

// File: rtl/tick_interval_counter.sv
// Saturating cycle counter reloaded to 1 on every tick, with timeout compare.
module tick_interval_counter
    import tick_period_meter_pkg::*;
#(
    parameter int          WIDTH   = TPM_WIDTH,
    parameter int unsigned TIMEOUT = TPM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    output logic [WIDTH-1:0] cnt,
    output logic             at_limit
);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT);

    // On a tick the current value is the measured period; the reload
    // to 1 accounts for the tick cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= WIDTH'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/tick_period_meter.sv
// Measures cycles between ticks on bus.x, tracks lock and tick-train loss.
// Optional: define TICK_PERIOD_METER_JITTER_EN to accept +/-TOL as a match.
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int          WIDTH   = TPM_WIDTH,
    parameter int unsigned TIMEOUT = TPM_TIMEOUT,
    parameter int unsigned TOL     = TPM_TOL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tick_period_meter_if.master  bus
);
    localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

    if (TIMEOUT == 0 || 64'(TIMEOUT) > MAXV || 64'(TOL) > MAXV) begin : g_bad_cfg
        $error("tick_period_meter: TIMEOUT/TOL out of range for WIDTH");
    end

    tpm_state_t       state, state_next;
    logic [WIDTH-1:0] cnt;
    logic             at_limit;
    logic [WIDTH-1:0] prev, prev_next;
    logic             emit;
    logic             match;
    logic             timeout_hit;

    logic [WIDTH-1:0] period;
    logic             valid;
    logic             timeout_p;
    logic             overrun_p;

    tick_interval_counter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (bus.x),
        .cnt      (cnt),
        .at_limit (at_limit)
    );

`ifdef TICK_PERIOD_METER_JITTER_EN
    localparam logic [WIDTH-1:0] TOL_W = WIDTH'(TOL);
    logic [WIDTH-1:0] diff;
    assign diff  = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
    assign match = (diff <= TOL_W);
`else
    assign match = (cnt == prev);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prev  <= '0;
        end else begin
            state <= state_next;
            prev  <= prev_next;
        end
    end

    always_comb begin
        state_next  = state;
        prev_next   = prev;
        timeout_hit = 1'b0;
        emit        = bus.x && (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.x) state_next = ARMED;
            end
            ARMED: begin
                if (bus.x) begin
                    state_next = TRACK;
                    prev_next  = cnt;
                end
            end
            TRACK: begin
                if (bus.x) begin
                    if (match) state_next = LOCKED;
                    prev_next = cnt;
                end
            end
            LOCKED: begin
                if (bus.x) begin
                    if (!match) state_next = TRACK;
                    prev_next = cnt;
                end
            end
            default: state_next = IDLE;
        endcase
        // Silence long enough to reach TIMEOUT means the train is gone.
        if (state != IDLE && !bus.x && at_limit) begin
            state_next  = IDLE;
            prev_next   = '0;
            timeout_hit = 1'b1;
        end
    end

    // A sample loads when the slot is free or drains in the same cycle;
    // otherwise it is dropped and flagged, but lock tracking still sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period    <= '0;
            valid     <= 1'b0;
            timeout_p <= 1'b0;
            overrun_p <= 1'b0;
        end else begin
            timeout_p <= timeout_hit;
            overrun_p <= emit && valid && !bus.ready_i;
            if (emit && (!valid || bus.ready_i)) begin
                period <= cnt;
                valid  <= 1'b1;
            end else if (valid && bus.ready_i) begin
                valid <= 1'b0;
            end
        end
    end

    assign bus.period_o  = period;
    assign bus.valid_o   = valid;
    assign bus.locked_o  = (state == LOCKED);
    assign bus.timeout_o = timeout_p;
    assign bus.overrun_o = overrun_p;

endmodule
